// File: rtl/lcd_pkg.sv
// lcd_pkg
//   Shared definitions for the HD44780 write engine: FSM state encoding,
//   command codes that need the long execution wait, and bus-width constants.
package lcd_pkg;

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    ENHI,
    HOLD,
    EXEC
  } lcd_state_e;

  localparam logic [7:0] LCD_CMD_CLEAR = 8'h01;
  localparam logic [7:0] LCD_CMD_HOME  = 8'h02;

  localparam int BUS_8 = 8;
  localparam int BUS_4 = 4;

  // Clear display and return home take ~1.5 ms on the controller. 0x03 also
  // decodes as return-home because bit 0 of that command is don't-care.
  function automatic logic is_long_cmd(input logic rs, input logic [7:0] b);
    return !rs && ((b == LCD_CMD_CLEAR) || (b == LCD_CMD_HOME) ||
                   (b == (LCD_CMD_HOME | LCD_CMD_CLEAR)));
  endfunction

endpackage

// File: rtl/lcd_bus_engine_if.sv
// lcd_bus_engine_if
//   Byte request handshake between the LCD sequencer (master) and the write
//   engine (slave).
//     data   [7:0]  byte to write
//     rs            0 = command, 1 = display data
//     nibble        4-bit bus only: send data[7:4] as a lone nibble
//     valid         request valid, held until accepted
//     ready         engine idle, request accepted on a clock with valid
//     done          one-cycle pulse once the byte and its exec wait finished
interface lcd_bus_engine_if;
  logic [7:0] data;
  logic       rs;
  logic       nibble;
  logic       valid;
  logic       ready;
  logic       done;

  modport master (output data, rs, nibble, valid, input ready, done);
  modport slave  (input data, rs, nibble, valid, output ready, done);
endinterface

// File: rtl/lcd_delay_cnt.sv
// lcd_delay_cnt
//   Loadable down-counter shared by every timed state of the write engine.
//   Loading (len-1) gives a phase of exactly len cycles ending when zero_o
//   is seen. Holds at zero instead of wrapping.
//     clk_i, iRST_N   clock, asynchronous active-low reset
//     load_i          load load_val_i this cycle (has priority)
//     load_val_i      value to load
//     zero_o          counter is at zero
module lcd_delay_cnt #(
  parameter int W = 8
) (
  input  logic         clk_i,
  input  logic         iRST_N,
  input  logic         load_i,
  input  logic [W-1:0] load_val_i,
  output logic         zero_o
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = load_val_i;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - W'(1);
    end
  end

  always_ff @(posedge clk_i or negedge iRST_N) begin
    if (!iRST_N) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/lcd_bus_engine.sv
// lcd_bus_engine
//   HD44780 write engine. Accepts one byte per valid/ready handshake and plays
//   it onto the LCD pins with programmable setup / enable-pulse / hold timing,
//   then waits out the controller's execution time before signalling done.
//   On a 4-bit bus the byte is sent high nibble first as two pulses, unless
//   the request asks for a single nibble (used by the init sequence).
//     clk_i, iRST_N   clock, asynchronous active-low reset
//     req             request handshake (slave side)
//     LCD_DATA        LCD data pins (BUS_MODE wide)
//     LCD_RW          always 0, the engine only writes
//     LCD_EN          enable strobe
//     LCD_RS          register select
module lcd_bus_engine
  import lcd_pkg::*;
#(
  parameter int BUS_MODE    = 8,
  parameter int T_AS        = 2,
  parameter int T_PW        = 16,
  parameter int T_H         = 2,
  parameter int T_EXEC      = 2000,
  parameter int T_EXEC_LONG = 82000
) (
  input  logic                clk_i,
  input  logic                iRST_N,
  lcd_bus_engine_if.slave     req,
  output logic [BUS_MODE-1:0] LCD_DATA,
  output logic                LCD_RW,
  output logic                LCD_EN,
  output logic                LCD_RS
);

  localparam int CW = $clog2(T_EXEC_LONG + 1);

  localparam logic [CW-1:0] LD_AS        = CW'(T_AS - 1);
  localparam logic [CW-1:0] LD_PW        = CW'(T_PW - 1);
  localparam logic [CW-1:0] LD_H         = CW'(T_H - 1);
  localparam logic [CW-1:0] LD_EXEC      = CW'(T_EXEC - 1);
  localparam logic [CW-1:0] LD_EXEC_LONG = CW'(T_EXEC_LONG - 1);

  generate
    if ((BUS_MODE != BUS_8) && (BUS_MODE != BUS_4)) begin : g_bad_bus
      $error("lcd_bus_engine: BUS_MODE must be 8 or 4");
    end
    if ((T_AS < 1) || (T_PW < 1) || (T_H < 1) || (T_EXEC < 1) ||
        (T_EXEC_LONG < T_EXEC)) begin : g_bad_timing
      $error("lcd_bus_engine: illegal timing parameters");
    end
  endgenerate

  lcd_state_e          state_q, state_d;
  logic [7:0]          byte_q, byte_d;
  logic                nib_q, nib_d;      // single-nibble request
  logic                low_q, low_d;      // second (low) nibble in flight
  logic [BUS_MODE-1:0] data_q, data_d;
  logic                rs_q, rs_d;
  logic                en_q, en_d;
  logic                ready_q, ready_d;
  logic                done_q, done_d;

  logic                cnt_load;
  logic [CW-1:0]       cnt_val;
  logic                cnt_zero;

  lcd_delay_cnt #(.W(CW)) u_delay (
    .clk_i      (clk_i),
    .iRST_N     (iRST_N),
    .load_i     (cnt_load),
    .load_val_i (cnt_val),
    .zero_o     (cnt_zero)
  );

  always_comb begin
    state_d  = state_q;
    byte_d   = byte_q;
    nib_d    = nib_q;
    low_d    = low_q;
    data_d   = data_q;
    rs_d     = rs_q;
    done_d   = 1'b0;
    cnt_load = 1'b0;
    cnt_val  = '0;

    unique case (state_q)
      IDLE: begin
        if (req.valid) begin
          byte_d   = req.data;
          rs_d     = req.rs;
          nib_d    = (BUS_MODE == BUS_4) && req.nibble;
          low_d    = 1'b0;
          data_d   = (BUS_MODE == BUS_4) ? BUS_MODE'(req.data[7:4])
                                         : BUS_MODE'(req.data);
          state_d  = SETUP;
          cnt_load = 1'b1;
          cnt_val  = LD_AS;
        end
      end
      SETUP: begin
        if (cnt_zero) begin
          state_d  = ENHI;
          cnt_load = 1'b1;
          cnt_val  = LD_PW;
        end
      end
      ENHI: begin
        if (cnt_zero) begin
          state_d  = HOLD;
          cnt_load = 1'b1;
          cnt_val  = LD_H;
        end
      end
      HOLD: begin
        if (cnt_zero) begin
          cnt_load = 1'b1;
          if ((BUS_MODE == BUS_4) && !low_q && !nib_q) begin
            // Low nibble goes out only after the high nibble's hold time.
            low_d   = 1'b1;
            data_d  = BUS_MODE'(byte_q[3:0]);
            state_d = SETUP;
            cnt_val = LD_AS;
          end else begin
            state_d = EXEC;
            cnt_val = is_long_cmd(rs_q, byte_q) ? LD_EXEC_LONG : LD_EXEC;
          end
        end
      end
      EXEC: begin
        if (cnt_zero) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    // Registered copies of state-derived outputs so the pins are glitch-free.
    en_d    = (state_d == ENHI);
    ready_d = (state_d == IDLE);
  end

  always_ff @(posedge clk_i or negedge iRST_N) begin
    if (!iRST_N) begin
      state_q <= IDLE;
      byte_q  <= '0;
      nib_q   <= 1'b0;
      low_q   <= 1'b0;
      data_q  <= '0;
      rs_q    <= 1'b0;
      en_q    <= 1'b0;
      ready_q <= 1'b1;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      byte_q  <= byte_d;
      nib_q   <= nib_d;
      low_q   <= low_d;
      data_q  <= data_d;
      rs_q    <= rs_d;
      en_q    <= en_d;
      ready_q <= ready_d;
      done_q  <= done_d;
    end
  end

  assign LCD_DATA  = data_q;
  assign LCD_RW    = 1'b0;
  assign LCD_EN    = en_q;
  assign LCD_RS    = rs_q;
  assign req.ready = ready_q;
  assign req.done  = done_q;

endmodule
